// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and WIDTH bounds.
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Full-adder bit cell built from two half-adder stages and an OR for the carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  assign ha0_s = a ^ b;
  assign ha0_c = a & b;
  assign s     = ha0_s ^ ci;
  assign ha1_c = ha0_s & ci;
  assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per add, one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_OVF_EN enables the registered two's-complement overflow flag.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-2:0]   sum_sh_q;
  logic [CW-1:0]      cnt_q;
  logic               carry_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   sum_cat;

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New bit enters at the MSB; on the last step this is the complete result.
  assign sum_cat = {fa_s, sum_sh_q};

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // DONE lasts one cycle but accepts a new start just like IDLE.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            a_sh_q   <= a;
            b_sh_q   <= b;
            carry_q  <= cin;
            cnt_q    <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_cat[WIDTH-1:1];
          carry_q  <= fa_co;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= sum_cat;
            cout_q  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q here is the carry into the MSB.
            ovf_q   <= carry_q ^ fa_co;
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 vectors plus WIDTH=4 exhaustive sweep).
module tb_serial_adder;

`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout, overflow;
  logic [7:0] sum;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4, overflow4;
  logic [3:0] sum4;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(overflow4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Launch one WIDTH=8 add and wait for done; lat = edges from accept to done (-1 on timeout).
  task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                      output int lat, output bit busy_dropped);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_dropped = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_dropped = 1'b1;
    end
  endtask

  initial begin
    int  lat;
    bit  bd;
    logic [7:0] held;

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sum", {24'd0, sum}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bd);
      $display("[TB] vec %0d: %02h + %02h + %0d -> sum=%02h cout=%0d ovf=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, sum, cout, overflow, lat);
      chk($sformatf("vec%0d_sum", i), {24'd0, sum}, {24'd0, vecs[i].sum});
      chk($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].cout});
      chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].ovf & OVF_EN});
      chk($sformatf("vec%0d_latency", i), lat, 32'd8);
      chk($sformatf("vec%0d_busy_held", i), {31'd0, bd}, 32'd0);
    end

    // Result holds and done is a single pulse
    held = sum;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sum", {24'd0, sum}, {24'd0, held});
    chk("hold_done_low", {31'd0, done}, 32'd0);

    // Start during RUN is ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; bd = 1'b0;
    for (int i = 4; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      if (!busy) bd = 1'b1;
    end
    $display("[TB] ignored-start: sum=%02h lat=%0d", sum, lat);
    chk("ign_sum", {24'd0, sum}, 32'h30);
    chk("ign_latency", lat, 32'd8);
    chk("ign_busy_held", {31'd0, bd}, 32'd0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    a = 8'h5A; b = 8'h33; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    $display("[TB] reset mid-run: busy=%0d done=%0d sum=%02h", busy, done, sum);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_sum", {24'd0, sum}, 32'd0);
    chk("arst_cout", {31'd0, cout}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h01, 8'h01, 1'b0, lat, bd);
    $display("[TB] post-reset: sum=%02h lat=%0d", sum, lat);
    chk("post_rst_sum", {24'd0, sum}, 32'h02);
    chk("post_rst_latency", lat, 32'd8);

    // Back-to-back start held in DONE
    run8(8'h10, 8'h20, 1'b0, lat, bd);
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done_once", {31'd0, done}, 32'd0);
    chk("b2b_busy_rise", {31'd0, busy}, 32'd1);
    lat = -1;
    for (int i = 2; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    $display("[TB] back-to-back: sum=%02h ovf=%0d gap=%0d", sum, overflow, lat);
    chk("b2b_gap", lat, 32'd9);
    chk("b2b_sum", {24'd0, sum}, 32'h80);
    chk("b2b_ovf", {31'd0, overflow}, {31'd0, OVF_EN});

    // Exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          logic [4:0] exp5;
          logic       exp_ovf;
          bit         seen;
          exp5 = 5'(ia) + 5'(ib) + 5'(ic);
          exp_ovf = OVF_EN & (ia[3] == ib[3]) & (exp5[3] != ia[3]);
          @(negedge clk);
          a4 = 4'(ia); b4 = 4'(ib); cin4 = ic[0]; start4 = 1'b1;
          @(posedge clk); #1;
          start4 = 1'b0;
          seen = 1'b0;
          for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done4) begin seen = 1'b1; break; end
          end
          $display("[TB] w4: %0h + %0h + %0d -> %0d%02h ovf=%0d", ia, ib, ic, cout4, sum4, overflow4);
          chk($sformatf("w4_%0h_%0h_%0d", ia, ib, ic),
              {25'd0, seen, overflow4, cout4, sum4}, {25'd0, 1'b1, exp_ovf, exp5});
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
